// File: rtl/flag_branch_unit_pkg.sv
// Shared encodings and helpers for the flag/branch unit: ALU ops, branch codes,
// flag bit positions and the pending-slot layout.
package flag_branch_unit_pkg;

    localparam int CCW    = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_NOR = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SRA = 3'd6,
        ALU_LHB = 3'd7
    } alu_op_e;

    typedef enum logic [CCW-1:0] {
        BR_NE     = 3'd0,
        BR_EQ     = 3'd1,
        BR_GT     = 3'd2,
        BR_LT     = 3'd3,
        BR_GE     = 3'd4,
        BR_LE     = 3'd5,
        BR_OV     = 3'd6,
        BR_UNCOND = 3'd7
    } br_cond_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] mask;
        logic [2:0] nzv;
    } pend_t;

    // Which of {N,Z,V} an ALU op is allowed to update.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        logic [2:0] m;
        case (op)
            ALU_ADD, ALU_SUB:                   m = 3'b111;
            ALU_AND, ALU_NOR, ALU_SLL,
            ALU_SRL, ALU_SRA:                   m = 3'b010;
            default:                            m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] merge_flags(input logic [2:0] old_f,
                                               input logic [2:0] new_f,
                                               input logic [2:0] mask);
        return (new_f & mask) | (old_f & ~mask);
    endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage to flag/branch unit bundle; master is the pipeline, slave is the unit.
interface flag_branch_unit_if #(parameter int DW = 16);
    logic          ex_valid;
    logic [2:0]    ex_aluOp;
    logic [DW-1:0] ex_dst;
    logic          ex_zr;
    logic          ex_ov;
    logic          br_valid;
    logic [2:0]    br_cond;
    logic          stall;
    logic          flush;
    logic          clr_sticky;
    logic          br_taken;
    logic [2:0]    flags;
    logic          ov_sticky;

    modport master (
        output ex_valid, ex_aluOp, ex_dst, ex_zr, ex_ov,
        output br_valid, br_cond, stall, flush, clr_sticky,
        input  br_taken, flags, ov_sticky
    );

    modport slave (
        input  ex_valid, ex_aluOp, ex_dst, ex_zr, ex_ov,
        input  br_valid, br_cond, stall, flush, clr_sticky,
        output br_taken, flags, ov_sticky
    );
endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Pure combinational evaluation of a branch condition code against {N,Z,V}.
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0]     eff,
    input  logic [CCW-1:0] cond,
    output logic           take
);

    logic n_s;
    logic z_s;
    logic v_s;

    assign n_s = eff[FLAG_N];
    assign z_s = eff[FLAG_Z];
    assign v_s = eff[FLAG_V];

    // Condition-code decode.
    always_comb begin
        take = 1'b0;
        case (cond)
            BR_NE:     take = ~z_s;
            BR_EQ:     take = z_s;
            BR_GT:     take = ~z_s & ~n_s;
            BR_LT:     take = n_s;
            BR_GE:     take = z_s | ~n_s;
            BR_LE:     take = n_s | z_s;
            BR_OV:     take = v_s;
            BR_UNCOND: take = 1'b1;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Captures ALU flags into a one-deep pending slot, commits them to the flag
// register, and resolves EX branches against the forwarded (youngest) flags.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    flag_branch_unit_if.slave bus
);

    pend_t      pend_r;
    logic [2:0] flags_r;
    logic       ov_sticky_r;
    logic       br_taken_r;

    pend_t      pend_nxt_s;
    logic [2:0] flags_nxt_s;
    logic       ov_sticky_nxt_s;
    logic       br_taken_nxt_s;
    logic [2:0] mask_s;
    logic       cap_s;
    logic       commit_s;
    logic [2:0] eff_s;
    logic       take_s;

    branch_cond_eval u_cond (
        .eff  (eff_s),
        .cond (bus.br_cond),
        .take (take_s)
    );

    // Next-state for the pending slot, flag register, sticky bit and redirect.
    always_comb begin
        mask_s   = flag_mask(bus.ex_aluOp);
        cap_s    = bus.ex_valid & ~bus.br_valid & ~bus.flush & ~bus.stall & (mask_s != 3'b000);
        commit_s = ~bus.stall & pend_r.valid;

        if (pend_r.valid) begin
            eff_s = merge_flags(flags_r, pend_r.nzv, pend_r.mask);
        end else begin
            eff_s = flags_r;
        end

        pend_nxt_s = pend_r;
        if (cap_s) begin
            pend_nxt_s.valid = 1'b1;
            pend_nxt_s.mask  = mask_s;
            pend_nxt_s.nzv   = {bus.ex_dst[DW-1], bus.ex_zr, bus.ex_ov};
        end else if (!bus.stall) begin
            pend_nxt_s.valid = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end

        if (commit_s) begin
            flags_nxt_s = merge_flags(flags_r, pend_r.nzv, pend_r.mask);
        end else begin
            flags_nxt_s = flags_r;
        end

        // A V=1 commit beats a simultaneous clear request.
        if (commit_s && pend_r.mask[FLAG_V] && pend_r.nzv[FLAG_V]) begin
            ov_sticky_nxt_s = 1'b1;
        end else if (!bus.stall && bus.clr_sticky) begin
            ov_sticky_nxt_s = 1'b0;
        end else begin
            ov_sticky_nxt_s = ov_sticky_r;
        end

        br_taken_nxt_s = bus.br_valid & bus.ex_valid & ~bus.flush & ~bus.stall & take_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r      <= '{valid: 1'b0, mask: 3'b000, nzv: 3'b000};
            flags_r     <= 3'b000;
            ov_sticky_r <= 1'b0;
            br_taken_r  <= 1'b0;
        end else begin
            pend_r      <= pend_nxt_s;
            flags_r     <= flags_nxt_s;
            ov_sticky_r <= ov_sticky_nxt_s;
            br_taken_r  <= br_taken_nxt_s;
        end
    end

    assign bus.br_taken  = br_taken_r;
    assign bus.flags     = flags_r;
    assign bus.ov_sticky = ov_sticky_r;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scenario bench for flag_branch_unit: hand-derived expected outputs are queued
// as each cycle is driven and popped/compared after the clock edge.
module tb_flag_branch_unit;
    import flag_branch_unit_pkg::*;

    typedef struct packed {
        logic        rstn;
        logic        v;
        logic [2:0]  op;
        logic [15:0] dst;
        logic        zr;
        logic        ov;
        logic        brv;
        logic [2:0]  cond;
        logic        stall;
        logic        flush;
        logic        clr;
    } stim_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [4:0] sb[$];

    flag_branch_unit_if #(.DW(16)) bus ();

    flag_branch_unit #(.DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic v, logic [2:0] op, logic [15:0] dst, logic zr, logic ov,
                                 logic brv, logic [2:0] cond, logic stall, logic flush, logic clr);
        stim_t t;
        t.rstn = 1'b1; t.v = v; t.op = op; t.dst = dst; t.zr = zr; t.ov = ov;
        t.brv = brv; t.cond = cond; t.stall = stall; t.flush = flush; t.clr = clr;
        return t;
    endfunction

    function automatic stim_t alu_s(logic [2:0] op, logic [15:0] dst, logic zr, logic ov, logic flush);
        return mk(1'b1, op, dst, zr, ov, 1'b0, BR_NE, 1'b0, flush, 1'b0);
    endfunction

    // Branches carry a flag-setting op with junk flags: it must never be captured.
    function automatic stim_t br_s(logic [2:0] cond, logic stall, logic flush);
        return mk(1'b1, ALU_ADD, 16'hFFFF, 1'b0, 1'b1, 1'b1, cond, stall, flush, 1'b0);
    endfunction

    function automatic stim_t idle_s(logic stall, logic clr);
        return mk(1'b0, ALU_LHB, 16'h0000, 1'b0, 1'b0, 1'b0, BR_NE, stall, 1'b0, clr);
    endfunction

    function automatic stim_t rst_s();
        stim_t t;
        t = idle_s(1'b0, 1'b0);
        t.rstn = 1'b0;
        return t;
    endfunction

    function automatic logic [4:0] ex(logic br, logic [2:0] f, logic st);
        return {br, f, st};
    endfunction

    function automatic logic [4:0] obs();
        return {bus.br_taken, bus.flags, bus.ov_sticky};
    endfunction

    task automatic apply(input stim_t t, input logic [4:0] want);
        rst_n          = t.rstn;
        bus.ex_valid   = t.v;
        bus.ex_aluOp   = t.op;
        bus.ex_dst     = t.dst;
        bus.ex_zr      = t.zr;
        bus.ex_ov      = t.ov;
        bus.br_valid   = t.brv;
        bus.br_cond    = t.cond;
        bus.stall      = t.stall;
        bus.flush      = t.flush;
        bus.clr_sticky = t.clr;
        sb.push_back(want);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        s.push_back(rst_s());            e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(rst_s());            e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL reset cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        s.push_back(rst_s());                                  e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_ADD, 16'h7FFF, 1'b0, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b001, 1'b1));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b001, 1'b1));
        s.push_back(idle_s(1'b0, 1'b1));                       e.push_back(ex(1'b0, 3'b001, 1'b0));
        s.push_back(alu_s(ALU_SUB, 16'h8000, 1'b0, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b001, 1'b0));
        s.push_back(idle_s(1'b0, 1'b1));                       e.push_back(ex(1'b0, 3'b101, 1'b1));
        s.push_back(idle_s(1'b0, 1'b1));                       e.push_back(ex(1'b0, 3'b101, 1'b0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL overflow cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_forward_eq();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        s.push_back(rst_s());                                  e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_SUB, 16'h0000, 1'b1, 1'b0, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b010, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b010, 1'b0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL forward_eq cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_partial_mask();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        s.push_back(rst_s());                                  e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_ADD, 16'h8000, 1'b0, 1'b0, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_AND, 16'h8000, 1'b0, 1'b0, 1'b0)); e.push_back(ex(1'b0, 3'b100, 1'b0));
        s.push_back(br_s(BR_LT, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b100, 1'b0));
        s.push_back(br_s(BR_GT, 1'b0, 1'b0));                  e.push_back(ex(1'b0, 3'b100, 1'b0));
        s.push_back(alu_s(ALU_AND, 16'h0000, 1'b1, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b100, 1'b0));
        s.push_back(br_s(BR_LE, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b110, 1'b0));
        s.push_back(br_s(BR_GE, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b110, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b110, 1'b0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL partial_mask cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_no_flag_op();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        s.push_back(rst_s());                                  e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_SUB, 16'h0000, 1'b1, 1'b0, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_LHB, 16'h8000, 1'b0, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(br_s(BR_NE, 1'b0, 1'b0));                  e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b010, 1'b0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL no_flag_op cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_flush_stall();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        s.push_back(rst_s());                                  e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_SUB, 16'h0000, 1'b1, 1'b0, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(alu_s(ALU_ADD, 16'h1234, 1'b0, 1'b0, 1'b1)); e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b010, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b1, 1'b0));                  e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b1, 1'b0));                  e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b1, 1'b0));                  e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(br_s(BR_EQ, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b010, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(alu_s(ALU_ADD, 16'h7FFF, 1'b0, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(idle_s(1'b1, 1'b0));                       e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(idle_s(1'b1, 1'b1));                       e.push_back(ex(1'b0, 3'b010, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b001, 1'b1));
        s.push_back(br_s(BR_OV, 1'b0, 1'b1));                  e.push_back(ex(1'b0, 3'b001, 1'b1));
        s.push_back(br_s(BR_OV, 1'b0, 1'b0));                  e.push_back(ex(1'b1, 3'b001, 1'b1));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL flush_stall cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        stim_t s[$];
        logic [4:0] e[$];
        logic [4:0] want;
        stim_t t;
        t = br_s(BR_UNCOND, 1'b0, 1'b0);
        t.rstn = 1'b0;
        s.push_back(rst_s());                                  e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(alu_s(ALU_ADD, 16'h7FFF, 1'b0, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b001, 1'b1));
        s.push_back(alu_s(ALU_SUB, 16'h8000, 1'b0, 1'b1, 1'b0)); e.push_back(ex(1'b0, 3'b001, 1'b1));
        s.push_back(t);                                        e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b000, 1'b0));
        s.push_back(br_s(BR_UNCOND, 1'b0, 1'b0));              e.push_back(ex(1'b1, 3'b000, 1'b0));
        s.push_back(idle_s(1'b0, 1'b0));                       e.push_back(ex(1'b0, 3'b000, 1'b0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL reset_mid_op cyc%0d got {br,nzv,st}=%b want=%b", i, obs(), want);
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.ex_aluOp   = 3'd0;
        bus.ex_dst     = 16'h0000;
        bus.ex_zr      = 1'b0;
        bus.ex_ov      = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_cond    = 3'd0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.clr_sticky = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_overflow();
        test_forward_eq();
        test_partial_mask();
        test_no_flag_op();
        test_flush_stall();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
